// File: rtl/sign_extend.sv
// Immediate-extension unit: combinational sign extension for the ALU operand mux,
// plus a registered, mode-selected immediate with a valid flag for the ID/EX stage.
module sign_extend #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [IN_W-1:0]  i_in,
    input  logic [1:0]       i_mode,
    input  logic             i_valid,
    input  logic             i_stall,
    output logic [OUT_W-1:0] extend_out,
    output logic [OUT_W-1:0] o_imm_q,
    output logic             o_valid_q
);

    localparam int unsigned EXT_W    = OUT_W - IN_W;
    localparam int unsigned UPPER_SH = OUT_W - IN_W;

    localparam logic [1:0] MODE_SIGN   = 2'b00;
    localparam logic [1:0] MODE_ZERO   = 2'b01;
    localparam logic [1:0] MODE_UPPER  = 2'b10;
    localparam logic [1:0] MODE_BRANCH = 2'b11;

    logic [OUT_W-1:0] sext_c;
    logic [OUT_W-1:0] zext_c;
    logic [OUT_W-1:0] sel_c;
    logic [OUT_W-1:0] imm_d;
    logic             valid_d;

    assign sext_c     = {{EXT_W{i_in[IN_W-1]}}, i_in};
    assign zext_c     = {{EXT_W{1'b0}}, i_in};
    assign extend_out = sext_c;

    // Mode select; unknown modes fall back to sign extension so nothing latches.
    always_comb begin
        sel_c = sext_c;
        case (i_mode)
            MODE_SIGN:   sel_c = sext_c;
            MODE_ZERO:   sel_c = zext_c;
            MODE_UPPER:  sel_c = zext_c << UPPER_SH;
            MODE_BRANCH: sel_c = sext_c << 2;
            default:     sel_c = sext_c;
        endcase
    end

    // Stall holds everything; a bubble clears valid but keeps the last immediate.
    always_comb begin
        imm_d   = o_imm_q;
        valid_d = o_valid_q;
        if (!i_stall) begin
            valid_d = i_valid;
            if (i_valid) begin
                imm_d = sel_c;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_imm_q   <= '0;
            o_valid_q <= 1'b0;
        end else begin
            o_imm_q   <= imm_d;
            o_valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_sign_extend.sv
// Bench for sign_extend: vector tables, directed stall/reset sequences and a
// randomised run checked through an expected-result queue.
module tb_sign_extend;

    logic        clk;
    logic        rst_n;
    logic [15:0] in_v;
    logic [1:0]  mode;
    logic        valid;
    logic        stall;
    logic [31:0] extend_out;
    logic [31:0] imm_q;
    logic        valid_q;

    sign_extend #(.IN_W(16), .OUT_W(32)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_in       (in_v),
        .i_mode     (mode),
        .i_valid    (valid),
        .i_stall    (stall),
        .extend_out (extend_out),
        .o_imm_q    (imm_q),
        .o_valid_q  (valid_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] imm;
        logic        v;
    } exp_t;

    typedef struct {
        logic [15:0] in;
        logic [31:0] exp;
    } comb_vec_t;

    typedef struct {
        logic [15:0] in;
        logic [1:0]  mode;
        logic [31:0] exp;
    } mode_vec_t;

    exp_t        sb[$];
    logic [31:0] m_imm;
    logic        m_valid;
    int          n_checks;
    int          n_fail;

    function automatic logic [31:0] ref_ext(input logic [15:0] x, input logic [1:0] md);
        int s;
        s = int'($signed(x));
        case (md)
            2'b00:   return 32'(s);
            2'b01:   return 32'(x);
            2'b10:   return {x, 16'h0000};
            default: return 32'(s * 4);
        endcase
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b, expected %0b", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus at a falling edge, predict, then compare after the rising edge.
    task automatic step(input logic [15:0] x, input logic [1:0] md, input logic v, input logic st,
                        input string name);
        exp_t e;
        in_v  = x;
        mode  = md;
        valid = v;
        stall = st;
        if (!st) begin
            m_valid = v;
            if (v) m_imm = ref_ext(x, md);
        end
        e.imm = m_imm;
        e.v   = m_valid;
        sb.push_back(e);
        #1;
        check32({name, " comb"}, extend_out, 32'(int'($signed(x))));
        @(posedge clk);
        @(negedge clk);
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got imm %08h", name, imm_q);
        end else begin
            e = sb.pop_front();
            check32({name, " imm"}, imm_q, e.imm);
            check1({name, " valid"}, valid_q, e.v);
        end
    endtask

    comb_vec_t cvec[5];
    mode_vec_t mvec[4];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_imm    = '0;
        m_valid  = 1'b0;

        cvec[0] = '{16'hFFFF, 32'hFFFF_FFFF};
        cvec[1] = '{16'h07FF, 32'h0000_07FF};
        cvec[2] = '{16'h8000, 32'hFFFF_8000};
        cvec[3] = '{16'h7FFF, 32'h0000_7FFF};
        cvec[4] = '{16'h0000, 32'h0000_0000};

        mvec[0] = '{16'h8004, 2'b00, 32'hFFFF_8004};
        mvec[1] = '{16'h8004, 2'b01, 32'h0000_8004};
        mvec[2] = '{16'h8004, 2'b10, 32'h8004_0000};
        mvec[3] = '{16'h8004, 2'b11, 32'hFFFE_0010};

        rst_n = 1'b0;
        in_v  = 16'hFFFF;
        mode  = 2'b00;
        valid = 1'b0;
        stall = 1'b0;
        #1;
        check32("reset imm", imm_q, 32'h0);
        check1("reset valid", valid_q, 1'b0);

        // Combinational path works while reset is held.
        for (int i = 0; i < 5; i++) begin
            in_v = cvec[i].in;
            #10;
            check32($sformatf("comb vec %0d", i), extend_out, cvec[i].exp);
        end

        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            step(mvec[i].in, mvec[i].mode, 1'b1, 1'b0, $sformatf("mode %0d", i));
            check32($sformatf("mode table %0d", i), imm_q, mvec[i].exp);
            check1($sformatf("mode table valid %0d", i), valid_q, 1'b1);
        end

        // Stall holds the captured value and valid flag.
        step(16'h1234, 2'b00, 1'b1, 1'b0, "capture 1234");
        for (int i = 0; i < 3; i++) begin
            step(16'hA000 + 16'(i), 2'(i), 1'(i % 2), 1'b1, $sformatf("stall %0d", i));
            check32($sformatf("stall hold %0d", i), imm_q, 32'h0000_1234);
            check1($sformatf("stall valid %0d", i), valid_q, 1'b1);
        end
        step(16'h5555, 2'b01, 1'b0, 1'b0, "bubble");
        check32("bubble imm", imm_q, 32'h0000_1234);
        check1("bubble valid", valid_q, 1'b0);

        // Asynchronous reset between edges, with stall and valid asserted.
        step(16'hFFFF, 2'b00, 1'b1, 1'b0, "load ffff");
        check32("load ffff imm", imm_q, 32'hFFFF_FFFF);
        in_v  = 16'h4321;
        valid = 1'b1;
        stall = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check32("async rst imm", imm_q, 32'h0);
        check1("async rst valid", valid_q, 1'b0);
        check32("async rst comb", extend_out, 32'h0000_4321);
        in_v = 16'hC001;
        stall = 1'b0;
        #1;
        check32("rst comb track", extend_out, 32'hFFFF_C001);
        @(negedge clk);
        check32("rst held imm", imm_q, 32'h0);
        check1("rst held valid", valid_q, 1'b0);
        sb.delete();
        m_imm   = '0;
        m_valid = 1'b0;
        rst_n   = 1'b1;

        // Random run starting on the cycle right after reset release.
        for (int i = 0; i < 1000; i++) begin
            step(16'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) == 0), $sformatf("rand %0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sign_extend.md
# sign_extend

Immediate-extension unit for the MIPS datapath decode stage. It widens a 16-bit instruction immediate to 32 bits. A combinational sign-extended result feeds the ALU operand mux directly. A registered, mode-selected result with a valid flag feeds the ID/EX pipeline register and the branch/LUI paths.

## Interface

Parameters:
- `IN_W`, 16: immediate input width.
- `OUT_W`, 32: extended output width; must be greater than `IN_W`.

Ports:
- `i_clk`, input, 1: clock; all registers update on the rising edge.
- `i_rst_n`, input, 1: reset, asynchronous, active-low.
- `i_in`, input, `IN_W`: immediate field, instr[15:0].
- `i_mode`, input, 2: extension mode for the registered path.
- `i_valid`, input, 1: `i_in` and `i_mode` qualify for capture this cycle.
- `i_stall`, input, 1: hold the registered outputs.
- `extend_out`, output, `OUT_W`: combinational sign extension of `i_in`.
- `o_imm_q`, output, `OUT_W`: registered, mode-selected extension.
- `o_valid_q`, output, 1: `o_imm_q` holds valid data.

## Operation

- `extend_out` = {{(`OUT_W`-`IN_W`){`i_in[IN_W-1]`}}, `i_in`}, purely combinational. It is independent of clock, reset, mode, valid and stall.
- `i_mode` encoding (applies to the registered path only):
  - 2'b00 SIGN: same value as `extend_out`.
  - 2'b01 ZERO: {zeros, `i_in`} (ANDI/ORI/XORI).
  - 2'b10 UPPER: {`i_in`, 16'h0000} (LUI). Defined for `OUT_W`=32 only.
  - 2'b11 BRANCH: sign-extend `i_in`, then shift left 2. Bits [1:0] = 0; the upper bits are lost modulo 2^32.
- Capture rules (registered path):
  - `i_stall`=1: `o_imm_q` and `o_valid_q` hold, regardless of `i_valid`.
  - `i_stall`=0, `i_valid`=1: `o_imm_q` <= selected result; `o_valid_q` <= 1.
  - `i_stall`=0, `i_valid`=0: `o_imm_q` holds its last value; `o_valid_q` <= 0.
- No state machine. The only state is the data register and the valid flag.
- X/Z on `i_mode` while `i_valid`=1 is a usage error. The implementation must not latch.

## Timing

- `extend_out`: zero-cycle latency; settles within the same delta/combinational path as `i_in`.
- `o_imm_q`/`o_valid_q`: one-cycle latency. Inputs sampled at rising edge N appear after edge N.
- Reset assertion (`i_rst_n`=0): immediately, without waiting for a clock, `o_imm_q` = 0 and `o_valid_q` = 0. Held while low.
- Reset deassertion: the first capture happens at the first rising edge with `i_rst_n`=1.
- Reset during stall: reset wins.
- Reset mid-transfer: the in-flight value is discarded and is not re-presented.
- `extend_out` is unaffected by reset.

## Test plan

- Combinational sign, negative: `i_in`=16'hFFFF -> `extend_out`=32'hFFFF_FFFF at once. Then `i_in`=16'h07FF after 10 time units -> `extend_out`=32'h0000_07FF.
- Boundary values on the combinational path:
  - 16'h8000 -> 32'hFFFF_8000.
  - 16'h7FFF -> 32'h0000_7FFF.
  - 16'h0000 -> 32'h0000_0000.
- Registered modes with `i_in`=16'h8004 and `i_valid`=1, one edge each:
  - mode 00 -> `o_imm_q`=32'hFFFF_8004.
  - mode 01 -> 32'h0000_8004.
  - mode 10 -> 32'h8004_0000.
  - mode 11 -> 32'hFFFE_0010.
  - `o_valid_q`=1 after each edge.
- Stall/valid:
  - Capture 16'h1234 in mode 00.
  - Assert `i_stall` for 3 edges while changing `i_in` -> `o_imm_q` stays 32'h0000_1234 and `o_valid_q` stays 1.
  - Deassert stall with `i_valid`=0 -> `o_valid_q`=0 and `o_imm_q` still 32'h0000_1234.
- Asynchronous reset: with `o_imm_q`=32'hFFFF_FFFF, pull `i_rst_n` low between edges -> `o_imm_q`=0 and `o_valid_q`=0 before the next edge, while `extend_out` still tracks `i_in`.
- Random: 1000 random `i_in`/`i_mode`/`i_valid`/`i_stall` vectors compared against a reference model, including the cycle right after reset release.
